// File: rtl/tlm_pkg.sv
// Shared encodings for the traffic light monitor: light codes, phase states and fault codes.
package tlm_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [2:0] {
    SYNC      = 3'd0,
    ALL_RED   = 3'd1,
    NS_GREEN  = 3'd2,
    NS_YELLOW = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    FAULT     = 3'd6
  } phase_t;

  // Lower numbers win when several faults appear in the same sample.
  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_ENCODING     = 3'd1;
  localparam logic [2:0] FC_CONFLICT     = 3'd2;
  localparam logic [2:0] FC_TRANSITION   = 3'd3;
  localparam logic [2:0] FC_GREEN_SHORT  = 3'd4;
  localparam logic [2:0] FC_YELLOW       = 3'd5;
  localparam logic [2:0] FC_ALLRED_SHORT = 3'd6;

endpackage

// File: rtl/tlm_light_decode.sv
// Decodes one {red,yellow,green} one-hot light bus; valid is low for any non-one-hot value.
module tlm_light_decode
  import tlm_pkg::*;
(
  input  logic [2:0] light,
  output logic       is_red,
  output logic       is_yellow,
  output logic       is_green,
  output logic       valid
);

  assign is_red    = (light == RED);
  assign is_yellow = (light == YELLOW);
  assign is_green  = (light == GREEN);
  assign valid     = is_red | is_yellow | is_green;

endmodule

// File: rtl/traffic_light_monitor.sv
// Protocol monitor for the NS/EW intersection light buses with a sticky fault latch.
// Dwell-time limit checks (fault codes 4-6) are built only when TLM_DWELL_CHECK_EN is defined.
module traffic_light_monitor
  import tlm_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 3,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_YELLOW = 12,
  parameter int MIN_ALLRED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       NS_light,
  input  logic [2:0]       EW_light,
  input  logic             fault_clr,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [15:0]      cycle_count
);

  phase_t     state, next_state, obs;
  logic [2:0] new_code;
  logic       green_seen, last_was_ns;
  logic       ns_red, ns_yellow, ns_green, ns_valid;
  logic       ew_red, ew_yellow, ew_green, ew_valid;
  logic       cycle_done;

  tlm_light_decode u_ns_decode (
    .light    (NS_light),
    .is_red   (ns_red),
    .is_yellow(ns_yellow),
    .is_green (ns_green),
    .valid    (ns_valid)
  );

  tlm_light_decode u_ew_decode (
    .light    (EW_light),
    .is_red   (ew_red),
    .is_yellow(ew_yellow),
    .is_green (ew_green),
    .valid    (ew_valid)
  );

`ifdef TLM_DWELL_CHECK_EN
  localparam logic [CNT_W-1:0] MIN_GREEN_C  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_YELLOW_C = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_YELLOW_C = CNT_W'(MAX_YELLOW);
  localparam logic [CNT_W-1:0] MIN_ALLRED_C = CNT_W'(MIN_ALLRED);

  logic first_allred;

  // The all-red entered straight from SYNC has no known start, so it is exempt from MIN_ALLRED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      first_allred <= 1'b0;
    else if (state == SYNC && next_state == ALL_RED)
      first_allred <= 1'b1;
    else if (state == ALL_RED && next_state != ALL_RED)
      first_allred <= 1'b0;
  end
`else
  // Limits have no effect without the dwell checks.
  if (MIN_YELLOW > MAX_YELLOW || MIN_GREEN < 0 || MIN_ALLRED < 0) begin : g_unused_limits
  end
`endif

  // Phase implied by the current sample; only meaningful when both buses are valid and not in conflict.
  always_comb begin
    obs = SYNC;
    if (ns_red && ew_red)         obs = ALL_RED;
    else if (ns_green && ew_red)  obs = NS_GREEN;
    else if (ns_yellow && ew_red) obs = NS_YELLOW;
    else if (ew_green && ns_red)  obs = EW_GREEN;
    else if (ew_yellow && ns_red) obs = EW_YELLOW;
  end

  always_comb begin
    next_state = state;
    new_code   = FC_NONE;
    if (!ns_valid || !ew_valid) begin
      new_code = FC_ENCODING;
    end else if (!ns_red && !ew_red) begin
      new_code = FC_CONFLICT;
    end else begin
      case (state)
        SYNC:
          if (obs == ALL_RED) next_state = ALL_RED;
        ALL_RED:
          case (obs)
            ALL_RED: ;
            NS_GREEN:
              if (green_seen && last_was_ns) new_code = FC_TRANSITION;
              else next_state = NS_GREEN;
            EW_GREEN:
              if (green_seen && !last_was_ns) new_code = FC_TRANSITION;
              else next_state = EW_GREEN;
            default: new_code = FC_TRANSITION;
          endcase
        NS_GREEN:
          if (obs == NS_YELLOW) next_state = NS_YELLOW;
          else if (obs != NS_GREEN) new_code = FC_TRANSITION;
        NS_YELLOW:
          if (obs == ALL_RED) next_state = ALL_RED;
          else if (obs != NS_YELLOW) new_code = FC_TRANSITION;
        EW_GREEN:
          if (obs == EW_YELLOW) next_state = EW_YELLOW;
          else if (obs != EW_GREEN) new_code = FC_TRANSITION;
        EW_YELLOW:
          if (obs == ALL_RED) next_state = ALL_RED;
          else if (obs != EW_YELLOW) new_code = FC_TRANSITION;
        default: ;
      endcase
    end
`ifdef TLM_DWELL_CHECK_EN
    if (new_code == FC_NONE) begin
      if ((state == NS_YELLOW || state == EW_YELLOW) && next_state == state &&
          dwell >= MAX_YELLOW_C) begin
        new_code = FC_YELLOW;
      end else if (next_state != state) begin
        case (state)
          NS_GREEN, EW_GREEN:
            if (dwell < MIN_GREEN_C) new_code = FC_GREEN_SHORT;
          NS_YELLOW, EW_YELLOW:
            if (dwell < MIN_YELLOW_C) new_code = FC_YELLOW;
          ALL_RED:
            if (!first_allred && dwell < MIN_ALLRED_C) new_code = FC_ALLRED_SHORT;
          default: ;
        endcase
      end
    end
`endif
    if (new_code != FC_NONE)
      next_state = FAULT;
    else if (state == FAULT && fault_clr)
      next_state = SYNC;
  end

  assign cycle_done = (state == NS_YELLOW || state == EW_YELLOW) && next_state == ALL_RED;
  assign fault      = (state == FAULT);
  assign phase      = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SYNC;
    else      state <= next_state;
  end

  // A fault seen together with fault_clr re-latches its own code instead of clearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      fault_code <= FC_NONE;
    else if (new_code != FC_NONE && (state != FAULT || fault_clr))
      fault_code <= new_code;
    else if (state == FAULT && fault_clr)
      fault_code <= FC_NONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      dwell <= '0;
    else if (next_state == SYNC || next_state == FAULT)
      dwell <= '0;
    else if (next_state != state)
      dwell <= CNT_W'(1);
    else if (dwell != '1)
      dwell <= dwell + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            cycle_count <= '0;
    else if (cycle_done) cycle_count <= cycle_count + 16'd1;
  end

  // Alternation memory is forgotten whenever the monitor resynchronises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      green_seen  <= 1'b0;
      last_was_ns <= 1'b0;
    end else if (next_state == SYNC) begin
      green_seen  <= 1'b0;
    end else if (state == ALL_RED && (next_state == NS_GREEN || next_state == EW_GREEN)) begin
      green_seen  <= 1'b1;
      last_was_ns <= (next_state == NS_GREEN);
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor; dwell-limit steps follow TLM_DWELL_CHECK_EN.
module tb_traffic_light_monitor;
  import tlm_pkg::*;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  NS_light = L_RED;
  logic [2:0]  EW_light = L_RED;
  logic        fault_clr = 1'b0;
  logic        fault;
  logic [2:0]  fault_code;
  logic [2:0]  phase;
  logic [7:0]  dwell;
  logic [15:0] cycle_count;

  int compared   = 0;
  int mismatched = 0;
  logic [15:0] cyc = 16'd0;

  traffic_light_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .NS_light   (NS_light),
    .EW_light   (EW_light),
    .fault_clr  (fault_clr),
    .fault      (fault),
    .fault_code (fault_code),
    .phase      (phase),
    .dwell      (dwell),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Holds one input pattern for n clock edges, leaving the bench 1 time unit after the last edge.
  task automatic applyStimulus(input logic [2:0] ns, input logic [2:0] ew, input logic clr, input int n);
    NS_light  = ns;
    EW_light  = ew;
    fault_clr = clr;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    fault_clr = 1'b0;
  endtask

  // exp_code < 0 leaves fault_code unchecked.
  task automatic checkOutput(input string tag, input logic exp_fault, input int exp_code,
                             input phase_t exp_phase, input logic [7:0] exp_dwell,
                             input logic [15:0] exp_cycles);
    compared++;
    assert (fault === exp_fault) else begin
      mismatched++;
      $error("[TB] FAIL %s.fault observed=%0b expected=%0b", tag, fault, exp_fault);
    end
    if (exp_code >= 0) begin
      compared++;
      assert (fault_code === 3'(exp_code)) else begin
        mismatched++;
        $error("[TB] FAIL %s.fault_code observed=%0d expected=%0d", tag, fault_code, exp_code);
      end
    end
    compared++;
    assert (phase === exp_phase) else begin
      mismatched++;
      $error("[TB] FAIL %s.phase observed=%0d expected=%0d", tag, phase, exp_phase);
    end
    compared++;
    assert (dwell === exp_dwell) else begin
      mismatched++;
      $error("[TB] FAIL %s.dwell observed=%0d expected=%0d", tag, dwell, exp_dwell);
    end
    compared++;
    assert (cycle_count === exp_cycles) else begin
      mismatched++;
      $error("[TB] FAIL %s.cycle_count observed=%0d expected=%0d", tag, cycle_count, exp_cycles);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 0, SYNC, 8'd0, 16'd0);
    rst = 1'b1;

    $display("[TB] legal sequence");
    applyStimulus(L_RED, L_RED, 1'b0, 2);
    checkOutput("allred_first", 1'b0, 0, ALL_RED, 8'd2, cyc);
    applyStimulus(L_GRN, L_RED, 1'b0, 1);
    checkOutput("ns_green_enter", 1'b0, 0, NS_GREEN, 8'd1, cyc);
    applyStimulus(L_GRN, L_RED, 1'b0, 9);
    checkOutput("ns_green_end", 1'b0, 0, NS_GREEN, 8'd10, cyc);
    applyStimulus(L_YEL, L_RED, 1'b0, 2);
    checkOutput("ns_yellow", 1'b0, 0, NS_YELLOW, 8'd2, cyc);
    applyStimulus(L_RED, L_RED, 1'b0, 2);
    cyc = 16'd1;
    checkOutput("allred_1", 1'b0, 0, ALL_RED, 8'd2, cyc);
    applyStimulus(L_RED, L_GRN, 1'b0, 10);
    checkOutput("ew_green", 1'b0, 0, EW_GREEN, 8'd10, cyc);
    applyStimulus(L_RED, L_YEL, 1'b0, 2);
    checkOutput("ew_yellow", 1'b0, 0, EW_YELLOW, 8'd2, cyc);
    applyStimulus(L_RED, L_RED, 1'b0, 2);
    cyc = 16'd2;
    checkOutput("allred_2", 1'b0, 0, ALL_RED, 8'd2, cyc);

    $display("[TB] conflict");
    applyStimulus(L_GRN, L_RED, 1'b0, 5);
    checkOutput("ns_green_again", 1'b0, 0, NS_GREEN, 8'd5, cyc);
    applyStimulus(L_GRN, L_GRN, 1'b0, 1);
    checkOutput("conflict", 1'b1, 2, FAULT, 8'd0, cyc);
    applyStimulus(L_RED, L_RED, 1'b1, 1);
    checkOutput("conflict_clr", 1'b0, -1, SYNC, 8'd0, cyc);
    applyStimulus(L_RED, L_RED, 1'b0, 1);
    checkOutput("resync_1", 1'b0, -1, ALL_RED, 8'd1, cyc);

    $display("[TB] illegal transition");
    applyStimulus(L_GRN, L_RED, 1'b0, 4);
    checkOutput("ns_green_4", 1'b0, -1, NS_GREEN, 8'd4, cyc);
    applyStimulus(L_RED, L_RED, 1'b0, 1);
    checkOutput("skip_yellow", 1'b1, 3, FAULT, 8'd0, cyc);
    applyStimulus(L_GRN, L_GRN, 1'b0, 1);
    checkOutput("sticky_code", 1'b1, 3, FAULT, 8'd0, cyc);
    applyStimulus(3'b110, L_RED, 1'b1, 1);
    checkOutput("clr_with_fault", 1'b1, 1, FAULT, 8'd0, cyc);
    applyStimulus(L_RED, L_RED, 1'b1, 1);
    checkOutput("illegal_clr", 1'b0, -1, SYNC, 8'd0, cyc);
    applyStimulus(L_RED, L_RED, 1'b0, 1);
    checkOutput("resync_2", 1'b0, -1, ALL_RED, 8'd1, cyc);

    $display("[TB] alternation");
    applyStimulus(L_RED, L_GRN, 1'b0, 4);
    checkOutput("alt_ew_green", 1'b0, -1, EW_GREEN, 8'd4, cyc);
    applyStimulus(L_RED, L_YEL, 1'b0, 2);
    applyStimulus(L_RED, L_RED, 1'b0, 2);
    cyc = 16'd3;
    checkOutput("alt_allred", 1'b0, -1, ALL_RED, 8'd2, cyc);
    applyStimulus(L_RED, L_GRN, 1'b0, 1);
    checkOutput("alt_repeat", 1'b1, 3, FAULT, 8'd0, cyc);
    applyStimulus(L_RED, L_RED, 1'b1, 1);
    applyStimulus(L_RED, L_RED, 1'b0, 1);
    checkOutput("resync_3", 1'b0, -1, ALL_RED, 8'd1, cyc);

    $display("[TB] encoding");
    applyStimulus(3'b110, L_GRN, 1'b0, 1);
    checkOutput("encoding", 1'b1, 1, FAULT, 8'd0, cyc);
    applyStimulus(L_RED, L_RED, 1'b1, 1);
    applyStimulus(L_RED, L_RED, 1'b0, 1);
    checkOutput("resync_4", 1'b0, -1, ALL_RED, 8'd1, cyc);

`ifdef TLM_DWELL_CHECK_EN
    $display("[TB] dwell limits");
    applyStimulus(L_GRN, L_RED, 1'b0, 2);
    checkOutput("short_green", 1'b0, -1, NS_GREEN, 8'd2, cyc);
    applyStimulus(L_YEL, L_RED, 1'b0, 1);
    checkOutput("green_too_short", 1'b1, 4, FAULT, 8'd0, cyc);
    applyStimulus(L_RED, L_RED, 1'b1, 1);
    applyStimulus(L_RED, L_RED, 1'b0, 1);
    applyStimulus(L_GRN, L_RED, 1'b0, 3);
    applyStimulus(L_YEL, L_RED, 1'b0, 12);
    checkOutput("yellow_12", 1'b0, -1, NS_YELLOW, 8'd12, cyc);
    applyStimulus(L_YEL, L_RED, 1'b0, 1);
    checkOutput("yellow_too_long", 1'b1, 5, FAULT, 8'd0, cyc);
    applyStimulus(L_RED, L_RED, 1'b1, 1);
    applyStimulus(L_RED, L_RED, 1'b0, 1);
    checkOutput("resync_5", 1'b0, -1, ALL_RED, 8'd1, cyc);
`else
    $display("[TB] dwell limits inactive");
    applyStimulus(L_GRN, L_RED, 1'b0, 2);
    applyStimulus(L_YEL, L_RED, 1'b0, 13);
    checkOutput("long_yellow_ok", 1'b0, 0, NS_YELLOW, 8'd13, cyc);
    applyStimulus(L_RED, L_RED, 1'b0, 1);
    cyc = 16'd4;
    checkOutput("allred_after_long", 1'b0, 0, ALL_RED, 8'd1, cyc);
`endif

    $display("[TB] reset and wrap");
    applyStimulus(L_RED, L_GRN, 1'b0, 3);
    checkOutput("ew_green_pre_reset", 1'b0, -1, EW_GREEN, 8'd3, cyc);
    rst = 1'b0;
    #2;
    checkOutput("async_reset", 1'b0, 0, SYNC, 8'd0, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(L_RED, L_RED, 1'b0, 1);
    checkOutput("post_reset_allred", 1'b0, 0, ALL_RED, 8'd1, 16'd0);
    applyStimulus(L_GRN, L_RED, 1'b0, 3);
    applyStimulus(L_YEL, L_RED, 1'b0, 2);
    force dut.cycle_count = 16'hFFFF;
    #1;
    release dut.cycle_count;
    checkOutput("preload", 1'b0, 0, NS_YELLOW, 8'd2, 16'hFFFF);
    applyStimulus(L_RED, L_RED, 1'b0, 1);
    checkOutput("wrap", 1'b0, 0, ALL_RED, 8'd1, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
